// File: rtl/tx_byte_entry.sv
// Push-button byte composer for the UART transmit path: four debounced buttons
// edit Tx_Data one nibble at a time, and a start/busy handshake sends it.
module tx_byte_entry #(
  parameter int unsigned DEBOUNCE_CYCLES = 100000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       BTN_Up,
  input  logic       BTN_Down,
  input  logic       BTN_Sel,
  input  logic       BTN_Send,
  input  logic       Mode,
  input  logic       Tx_Busy,
  output logic [7:0] Tx_Data,
  output logic       Tx_Start,
  output logic       Nibble_Sel,
  output logic       Send_Pending
);

  // state     | meaning
  // IDLE      | editing enabled, waiting for a Send press
  // REQ       | byte frozen, waiting for the transmitter to be free
  // WAIT_ACK  | start pulse issued, waiting for Tx_Busy to rise
  // WAIT_DONE | frame in flight, waiting for Tx_Busy to fall
  typedef enum logic [1:0] {
    S_IDLE      = 2'd0,
    S_REQ       = 2'd1,
    S_WAIT_ACK  = 2'd2,
    S_WAIT_DONE = 2'd3
  } state_t;

  localparam int unsigned   CW       = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] CNT_TERM = CW'(DEBOUNCE_CYCLES - 1);

  // Bit order of the per-button vectors: {Send, Sel, Down, Up}
  logic [3:0]    btn_raw;
  logic [3:0]    meta_q;
  logic [3:0]    sync_q;
  logic [3:0]    level_q;
  logic [3:0]    level_d;
  logic [3:0]    level_prev_q;
  logic [3:0]    press_q;
  logic [CW-1:0] cnt_q [4];
  logic [CW-1:0] cnt_d [4];

  logic          do_send;
  logic          do_sel;
  logic          do_up;
  logic          do_down;

  state_t        state_q;
  state_t        state_d;
  logic [7:0]    data_q;
  logic [7:0]    data_d;
  logic          nsel_q;
  logic          nsel_d;
  logic          start_q;
  logic          start_d;
  logic          pend_q;
  logic          pend_d;

  assign btn_raw = {BTN_Send, BTN_Sel, BTN_Down, BTN_Up};

  // The accepted level only flips after DEBOUNCE_CYCLES consecutive
  // synchronized samples disagree with it.
  always_comb begin
    for (int i = 0; i < 4; i++) begin
      cnt_d[i]   = cnt_q[i];
      level_d[i] = level_q[i];
      if (sync_q[i] == level_q[i]) begin
        cnt_d[i] = '0;
      end else if (cnt_q[i] == CNT_TERM) begin
        cnt_d[i]   = '0;
        level_d[i] = ~level_q[i];
      end else begin
        cnt_d[i] = cnt_q[i] + CW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      meta_q       <= '0;
      sync_q       <= '0;
      level_q      <= '0;
      level_prev_q <= '0;
      press_q      <= '0;
      for (int i = 0; i < 4; i++) begin
        cnt_q[i] <= '0;
      end
    end else begin
      meta_q       <= btn_raw;
      sync_q       <= meta_q;
      level_q      <= level_d;
      level_prev_q <= level_q;
      press_q      <= level_q & ~level_prev_q;
      for (int i = 0; i < 4; i++) begin
        cnt_q[i] <= cnt_d[i];
      end
    end
  end

  // Single winner per cycle; receive mode swallows every press.
  always_comb begin
    do_send = 1'b0;
    do_sel  = 1'b0;
    do_up   = 1'b0;
    do_down = 1'b0;
    if (Mode) begin
      if (press_q[3]) begin
        do_send = 1'b1;
      end else if (press_q[2]) begin
        do_sel = 1'b1;
      end else if (press_q[0]) begin
        do_up = 1'b1;
      end else if (press_q[1]) begin
        do_down = 1'b1;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    nsel_d  = nsel_q;
    start_d = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (do_send) begin
          state_d = S_REQ;
        end else if (do_sel) begin
          nsel_d = ~nsel_q;
        end else if (do_up || do_down) begin
          if (nsel_q) begin
            data_d[3:0] = do_up ? data_q[3:0] + 4'd1 : data_q[3:0] - 4'd1;
          end else begin
            data_d[7:4] = do_up ? data_q[7:4] + 4'd1 : data_q[7:4] - 4'd1;
          end
        end
      end
      S_REQ: begin
        if (!Tx_Busy) begin
          start_d = 1'b1;
          state_d = S_WAIT_ACK;
        end
      end
      S_WAIT_ACK: begin
        if (Tx_Busy) begin
          state_d = S_WAIT_DONE;
        end
      end
      S_WAIT_DONE: begin
        if (!Tx_Busy) begin
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
    pend_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      data_q  <= 8'h00;
      nsel_q  <= 1'b0;
      start_q <= 1'b0;
      pend_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      nsel_q  <= nsel_d;
      start_q <= start_d;
      pend_q  <= pend_d;
    end
  end

  assign Tx_Data      = data_q;
  assign Tx_Start     = start_q;
  assign Nibble_Sel   = nsel_q;
  assign Send_Pending = pend_q;

endmodule

// File: tb/tb_tx_byte_entry.sv
// Bench for tx_byte_entry: directed vectors for the edit/send corner cases plus
// random button/mode/busy traffic against a sample-window reference model.
module tb_tx_byte_entry;

  localparam int D      = 4;
  localparam int B_UP   = 0;
  localparam int B_DOWN = 1;
  localparam int B_SEL  = 2;
  localparam int B_SEND = 3;

  logic       clk     = 1'b0;
  logic       reset   = 1'b1;
  logic [3:0] btn     = 4'b0000;
  logic       Mode    = 1'b1;
  logic       Tx_Busy = 1'b0;
  logic [7:0] Tx_Data;
  logic       Tx_Start;
  logic       Nibble_Sel;
  logic       Send_Pending;

  tx_byte_entry #(.DEBOUNCE_CYCLES(D)) dut (
    .clk         (clk),
    .reset       (reset),
    .BTN_Up      (btn[B_UP]),
    .BTN_Down    (btn[B_DOWN]),
    .BTN_Sel     (btn[B_SEL]),
    .BTN_Send    (btn[B_SEND]),
    .Mode        (Mode),
    .Tx_Busy     (Tx_Busy),
    .Tx_Data     (Tx_Data),
    .Tx_Start    (Tx_Start),
    .Nibble_Sel  (Nibble_Sel),
    .Send_Pending(Send_Pending)
  );

  always #5 clk = ~clk;

  int n_pass   = 0;
  int n_total  = 0;
  int n_starts = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
  endtask

  // Reference model: a button's accepted level flips once the last D
  // synchronized samples (pin delayed by two edges) all disagree with it;
  // a rise acts two edges later.
  bit         win [4][D+2];
  bit [3:0]   acc, rose1, rose2;
  logic [7:0] m_data = 8'h00;
  bit         m_nsel, m_start, m_pend, m_started, m_seen_busy;

  task automatic bump(input int delta);
    int nib;
    nib = m_nsel ? int'(m_data[3:0]) : int'(m_data[7:4]);
    nib = (nib + delta + 16) % 16;
    if (m_nsel) m_data[3:0] = 4'(nib);
    else        m_data[7:4] = 4'(nib);
  endtask

  task automatic model_step();
    bit [3:0] press;
    bit       diff;
    if (reset) begin
      for (int b = 0; b < 4; b++)
        for (int i = 0; i < D + 2; i++) win[b][i] = 1'b0;
      acc = '0; rose1 = '0; rose2 = '0;
      m_data = 8'h00; m_nsel = 0; m_start = 0; m_pend = 0;
      m_started = 0; m_seen_busy = 0;
      return;
    end
    press   = rose2;
    m_start = 1'b0;
    if (m_pend) begin
      if (!m_started) begin
        if (!Tx_Busy) begin m_started = 1; m_start = 1; end
      end else if (!m_seen_busy) begin
        if (Tx_Busy) m_seen_busy = 1;
      end else if (!Tx_Busy) begin
        m_pend = 0; m_started = 0; m_seen_busy = 0;
      end
    end else if (Mode) begin
      if (press[B_SEND])      m_pend = 1;
      else if (press[B_SEL])  m_nsel = ~m_nsel;
      else if (press[B_UP])   bump(1);
      else if (press[B_DOWN]) bump(-1);
    end
    rose2 = rose1;
    for (int b = 0; b < 4; b++) begin
      for (int i = D + 1; i > 0; i--) win[b][i] = win[b][i-1];
      win[b][0] = btn[b];
      diff = 1'b1;
      for (int i = 2; i <= D + 1; i++) if (win[b][i] == acc[b]) diff = 1'b0;
      rose1[b] = 1'b0;
      if (diff) begin acc[b] = ~acc[b]; rose1[b] = acc[b]; end
    end
  endtask

  // Transmitter stand-in: busy for tx_len cycles after each start.
  bit tx_auto = 0;
  bit tx_rand = 0;
  int tx_len  = 20;
  int tx_cnt  = 0;

  task automatic tx_model();
    if (!tx_auto) return;
    if (Tx_Start) begin
      Tx_Busy = 1'b1; tx_cnt = tx_len;
    end else if (tx_cnt > 0) begin
      tx_cnt--;
      if (tx_cnt == 0) Tx_Busy = 1'b0;
    end else if (tx_rand) begin
      Tx_Busy = ($urandom_range(0, 7) == 0);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    @(negedge clk);
    check("model", {21'd0, Tx_Data, Nibble_Sel, Tx_Start, Send_Pending},
          {21'd0, m_data, m_nsel, m_start, m_pend});
    if (Tx_Start) n_starts++;
    tx_model();
  endtask

  task automatic press(input int b, input int hold);
    btn[b] = 1'b1;
    repeat (hold) tick();
    btn[b] = 1'b0;
    repeat (D + 8) tick();
  endtask

  typedef struct {
    int         b;
    logic [7:0] exp_data;
    logic       exp_nsel;
  } vec_t;

  vec_t tbl [18];

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    bit   bounce [5];
    int   base, starts_here, up_t;
    logic [7:0] start_data;
    bit   up_done, prev_busy, fell_last, seen;

    tbl[0] = '{B_SEL,  8'h10, 1'b1};
    tbl[1] = '{B_DOWN, 8'h1F, 1'b1};
    for (int i = 1; i <= 16; i++) tbl[i+1] = '{B_UP, {4'h1, 4'(i - 1)}, 1'b1};
    bounce = '{1, 0, 1, 1, 0};

    // Reset and single increment latency
    reset = 1'b1;
    repeat (3) tick();
    check("rst_data",  Tx_Data, 8'h00);
    check("rst_nsel",  Nibble_Sel, 1'b0);
    check("rst_start", Tx_Start, 1'b0);
    check("rst_pend",  Send_Pending, 1'b0);
    reset = 1'b0;
    tick();
    btn[B_UP] = 1'b1;
    for (int i = 1; i <= 10; i++) begin
      tick();
      if (i == 7) check("up_before", Tx_Data, 8'h00);
      if (i == 8) check("up_latency", Tx_Data, 8'h10);
    end
    btn[B_UP] = 1'b0;
    repeat (12) tick();
    check("up_single", Tx_Data, 8'h10);

    // Nibble select, wrap without borrow/carry
    for (int i = 0; i < 18; i++) begin
      press(tbl[i].b, 6);
      check($sformatf("tbl%0d_data", i), Tx_Data, tbl[i].exp_data);
      check($sformatf("tbl%0d_nsel", i), Nibble_Sel, tbl[i].exp_nsel);
    end

    // Glitch rejection
    btn[B_UP] = 1'b1;
    repeat (3) tick();
    btn[B_UP] = 1'b0;
    repeat (12) tick();
    check("glitch_short", Tx_Data, 8'h1F);
    for (int i = 0; i < 5; i++) begin
      btn[B_UP] = bounce[i];
      tick();
    end
    btn[B_UP] = 1'b0;
    repeat (12) tick();
    check("glitch_bounce", Tx_Data, 8'h1F);

    // Send handshake with A5
    reset = 1'b1;
    repeat (2) tick();
    reset = 1'b0;
    tick();
    repeat (10) press(B_UP, 6);
    press(B_SEL, 6);
    repeat (5) press(B_UP, 6);
    check("build_a5", Tx_Data, 8'hA5);
    tx_auto = 1; tx_len = 20;
    starts_here = 0; up_done = 0; up_t = 0; fell_last = 0; start_data = 8'h00;
    btn[B_SEND] = 1'b1;
    for (int c = 0; c < 70; c++) begin
      prev_busy = Tx_Busy;
      tick();
      if (c == 6) btn[B_SEND] = 1'b0;
      if (Tx_Start) begin starts_here++; start_data = Tx_Data; end
      if (Tx_Busy && !up_done) begin btn[B_UP] = 1'b1; up_t = c; up_done = 1; end
      if (up_done && c == up_t + 6) btn[B_UP] = 1'b0;
      if (fell_last) check("pend_drop", Send_Pending, 1'b0);
      fell_last = 0;
      if (prev_busy && !Tx_Busy) begin
        check("pend_hold", Send_Pending, 1'b1);
        fell_last = 1;
      end
    end
    check("start_count", starts_here, 1);
    check("start_data",  start_data, 8'hA5);
    check("data_frozen", Tx_Data, 8'hA5);
    check("pend_idle",   Send_Pending, 1'b0);
    tx_auto = 0; Tx_Busy = 1'b0;

    // Blocked start
    Tx_Busy = 1'b1;
    base = n_starts;
    btn[B_SEND] = 1'b1;
    repeat (6) tick();
    btn[B_SEND] = 1'b0;
    repeat (10) tick();
    check("blocked_nostart", n_starts - base, 0);
    check("blocked_pending", Send_Pending, 1'b1);
    Tx_Busy = 1'b0; tx_auto = 1; tx_len = 5; tx_cnt = 0;
    repeat (15) tick();
    check("blocked_onestart", n_starts - base, 1);
    check("blocked_done",     Send_Pending, 1'b0);
    tx_auto = 0; Tx_Busy = 1'b0;

    // Receive mode discards presses, held buttons do not re-fire
    Mode = 1'b0;
    base = n_starts;
    press(B_UP, 6);
    press(B_SEND, 6);
    check("gated_data",  Tx_Data, 8'hA5);
    check("gated_start", n_starts - base, 0);
    check("gated_pend",  Send_Pending, 1'b0);
    btn[B_UP] = 1'b1;
    repeat (10) tick();
    Mode = 1'b1;
    repeat (10) tick();
    btn[B_UP] = 1'b0;
    repeat (10) tick();
    check("held_mode", Tx_Data, 8'hA5);

    // Simultaneous Up+Down: Up wins
    btn[B_UP] = 1'b1; btn[B_DOWN] = 1'b1;
    repeat (6) tick();
    btn[B_UP] = 1'b0; btn[B_DOWN] = 1'b0;
    repeat (12) tick();
    check("simul_up", Tx_Data, 8'hA6);

    // Reset during WAIT_DONE
    tx_auto = 1; tx_len = 20; tx_cnt = 0;
    btn[B_SEND] = 1'b1;
    seen = 0;
    for (int c = 0; c < 40 && !seen; c++) begin
      tick();
      if (c == 6) btn[B_SEND] = 1'b0;
      if (Tx_Busy) seen = 1;
    end
    btn[B_SEND] = 1'b0;
    check("wait_busy", seen, 1'b1);
    repeat (3) tick();
    reset = 1'b1;
    tick();
    check("midrst_data",  Tx_Data, 8'h00);
    check("midrst_nsel",  Nibble_Sel, 1'b0);
    check("midrst_start", Tx_Start, 1'b0);
    check("midrst_pend",  Send_Pending, 1'b0);
    reset = 1'b0; tx_auto = 0; Tx_Busy = 1'b0; tx_cnt = 0;
    repeat (5) tick();
    check("midrst_idle", Send_Pending, 1'b0);

    // Random traffic against the model
    tx_auto = 1; tx_rand = 1; tx_cnt = 0;
    for (int c = 0; c < 4000; c++) begin
      for (int b = 0; b < 4; b++)
        if ($urandom_range(0, 7) == 0) btn[b] = ~btn[b];
      if ($urandom_range(0, 59) == 0) Mode = ~Mode;
      reset  = ($urandom_range(0, 699) == 0);
      tx_len = $urandom_range(1, 10);
      tick();
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
